// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared pipeline definitions for the instruction fetch stage.
//   - fetch FSM state encoding (IDLE / REQ / DROP)
//   - NOP word shown to decode when nothing is fetched
//   - default reset PC and PC step
//   - FIFO entry layout {pc, word} and a word-alignment helper
package inst_fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// fetch_queue: 2-entry FIFO of parameterised width.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write an entry (ignored when full unless popping this cycle)
//   pop           drop the head entry (ignored when empty)
//   flush         empty the queue synchronously (wins over push/pop)
//   rdata         head entry (combinational)
//   full, empty   occupancy flags; count = occupancy 0..2
module fetch_queue #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  // When full, push+pop writes the slot being popped this same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage with a single outstanding memory
// request and a 2-entry prefetch queue.
//   state | meaning
//   IDLE  | no request; queue full (or just out of reset)
//   REQ   | imem_req=1 at fetch PC, waiting for imem_ack
//   DROP  | request abandoned by redirect; next ack is discarded
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_rst                   synchronous flush to RESET_PC (beats redirect)
//   if_en                    decode accepts inst this cycle
//   redirect, redirect_pc    taken control transfer target
//   imem_req/addr/ack/data   instruction memory handshake
//   inst, inst_pc, if_valid  instruction presented to decode
//   perf_fetched/perf_stall  counters, live only with FETCH_PERF_EN defined
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        if_valid,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, fetch_pc_nxt;
  fetch_entry_t q_wdata, q_rdata;
  logic         q_full, q_empty;
  logic [1:0]   q_count, occ_nxt;
  logic         flush, push, pop;

  assign flush   = if_rst || redirect;
  // A response is only kept if it answers a live request and no flush
  // arrives with it; an ack in IDLE/DROP or alongside a flush is dropped.
  assign push    = (state == ST_REQ) && imem_ack && !flush;
  assign pop     = if_valid && if_en;
  assign q_wdata = '{pc: fetch_pc, word: imem_data};
  assign occ_nxt = flush ? 2'd0 : q_count + {1'b0, push} - {1'b0, pop};

  fetch_queue #(.W($bits(fetch_entry_t))) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      ST_IDLE: if (occ_nxt != 2'd2) state_nxt = ST_REQ;
      ST_REQ: begin
        if (flush)                             state_nxt = imem_ack ? ST_REQ : ST_DROP;
        else if (imem_ack && occ_nxt == 2'd2)  state_nxt = ST_IDLE;
      end
      ST_DROP: if (imem_ack) state_nxt = ST_REQ;
      default: state_nxt = ST_IDLE;
    endcase
    if (if_rst)        fetch_pc_nxt = RESET_PC;
    else if (redirect) fetch_pc_nxt = align_pc(redirect_pc);
    else if (push)     fetch_pc_nxt = fetch_pc + PC_STEP;
  end

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = fetch_pc;
  assign if_valid  = !q_empty;
  assign inst      = q_empty ? NOP_WORD : q_rdata.word;
  assign inst_pc   = q_empty ? fetch_pc : q_rdata.pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else if (if_rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop)                  perf_fetched <= perf_fetched + 32'd1;
      if (if_en && !if_valid)   perf_stall   <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_fetched = 32'd0;
  assign perf_stall   = 32'd0;
`endif

  // q_full is implied by count; kept visible for debug probing.
  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, if_rst, if_en, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] inst, inst_pc;
  logic        if_valid;
  logic [31:0] perf_fetched, perf_stall;

  logic        ack_tie, ack_man;
  logic [31:0] man_data;

  int n_cmp = 0;
  int n_mis = 0;

  // Memory model: word at address a is a ^ 32'hDEAD_0000.
  function automatic logic [31:0] mword(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_ack  = ack_tie ? imem_req : ack_man;
  assign imem_data = ack_tie ? mword(imem_addr) : man_data;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .if_rst       (if_rst),
    .if_en        (if_en),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .if_valid     (if_valid),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_rst = 1'b0; if_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ack_tie = 1'b0; ack_man = 1'b0; man_data = '0;
    #1;
    check("rst_req",     imem_req,     0);
    check("rst_addr",    imem_addr,    0);
    check("rst_valid",   if_valid,     0);
    check("rst_inst",    inst,         0);
    check("rst_inst_pc", inst_pc,      0);
    check("rst_perf_f",  perf_fetched, 0);
    check("rst_perf_s",  perf_stall,   0);

    // Streaming with ack tied to req.
    tick();
    rst = 1'b0; if_en = 1'b1; ack_tie = 1'b1;
    check("idle_req", imem_req, 0);
    tick();
    check("first_req",   imem_req,  1);
    check("first_addr",  imem_addr, 0);
    check("first_valid", if_valid,  0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stream_valid", if_valid,  1);
      check("stream_pc",    inst_pc,   32'(4 * k));
      check("stream_inst",  inst,      mword(32'(4 * k)));
      check("stream_addr",  imem_addr, 32'(4 * k + 4));
    end

    // if_rst flush, then hold with if_en=0 until full.
    if_rst = 1'b1;
    tick();
    if_rst = 1'b0;
    check("ifrst_valid", if_valid,  0);
    check("ifrst_addr",  imem_addr, 0);
    check("ifrst_req",   imem_req,  1);
    if_en = 1'b0;
    tick();
    check("hold_valid0", if_valid,  1);
    check("hold_pc0",    inst_pc,   0);
    check("hold_addr4",  imem_addr, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_req",   imem_req, 0);
      check("hold_pc",    inst_pc,  0);
      check("hold_valid", if_valid, 1);
      check("hold_inst",  inst,     mword(0));
    end
    if_en = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("rel_valid", if_valid, 1);
      check("rel_pc",    inst_pc,  32'(4 * k));
      check("rel_inst",  inst,     mword(32'(4 * k)));
    end

    // Delayed ack, redirect to 0x40 while waiting.
    ack_tie = 1'b0; ack_man = 1'b0;
    tick();
    check("dly_valid", if_valid,  0);
    check("dly_addr",  imem_addr, 32'h10);
    check("dly_req",   imem_req,  1);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("drop_req",   imem_req, 0);
    check("drop_valid", if_valid, 0);
    check("drop_pc",    inst_pc,  32'h40);
    tick();
    check("drop_req2", imem_req, 0);
    ack_man = 1'b1; man_data = 32'hBAD0_0010;
    tick();
    ack_man = 1'b0; ack_tie = 1'b1;
    check("after_drop_req",   imem_req,  1);
    check("after_drop_addr",  imem_addr, 32'h40);
    check("after_drop_valid", if_valid,  0);
    tick();
    check("redir_valid", if_valid, 1);
    check("redir_pc",    inst_pc,  32'h40);
    check("redir_inst",  inst,     mword(32'h40));

    // Redirect coinciding with ack of 0x8.
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect = 1'b0; ack_tie = 1'b0; ack_man = 1'b0;
    check("to8_addr",  imem_addr, 32'h8);
    check("to8_valid", if_valid,  0);
    tick();
    check("to8_stable", imem_addr, 32'h8);
    ack_man = 1'b1; man_data = mword(32'h8);
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0; ack_man = 1'b0; ack_tie = 1'b1;
    check("same_valid", if_valid,  0);
    check("same_addr",  imem_addr, 32'h100);
    check("same_req",   imem_req,  1);
    tick();
    check("same_pc",   inst_pc, 32'h100);
    check("same_inst", inst,    mword(32'h100));

    // if_rst beats redirect.
    if_rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    if_rst = 1'b0; redirect = 1'b0;
    check("prio_addr",  imem_addr, 0);
    check("prio_valid", if_valid,  0);
    check("prio_req",   imem_req,  1);
    tick();
    check("prio_pc", inst_pc, 0);
    tick();
    check("bub_pc", inst_pc, 4);
    ack_tie = 1'b0;
    tick();
    check("bub_valid1", if_valid, 0);
    tick();
    check("bub_valid2", if_valid, 0);
    ack_tie = 1'b1;
    for (int k = 2; k < 10; k++) begin
      tick();
      check("perf_run_pc", inst_pc, 32'(4 * k));
    end
    tick();
    if_en = 1'b0;
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 10);
    check("perf_stall",   perf_stall,   3);
`else
    check("perf_fetched", perf_fetched, 0);
    check("perf_stall",   perf_stall,   0);
`endif

    // Async reset mid-cycle, stale ack after release is ignored.
    #4;
    rst = 1'b1;
    #1;
    check("arst_valid", if_valid,     0);
    check("arst_req",   imem_req,     0);
    check("arst_inst",  inst,         0);
    check("arst_perf",  perf_fetched, 0);
    tick();
    rst = 1'b0; if_en = 1'b1; ack_tie = 1'b0; ack_man = 1'b1; man_data = 32'hBAD0_0BAD;
    tick();
    ack_man = 1'b0;
    check("post_rst_req",   imem_req,  1);
    check("post_rst_addr",  imem_addr, 0);
    check("post_rst_valid", if_valid,  0);
    tick();
    check("stale_valid", if_valid,  0);
    check("stale_addr",  imem_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset and on if_rst.
REQ-002 clk  in  1  main clock; single clock domain.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 if_rst  in  1  synchronous flush from the pipeline controller; reloads RESET_PC.
REQ-005 if_en  in  1  consumer accepts the current inst; 0 holds it.
REQ-006 redirect  in  1  taken jump/branch/jr resolved downstream.
REQ-007 redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  word-aligned request address.
REQ-010 imem_ack  in  1  memory response valid; may assert in the same cycle as imem_req or any later cycle.
REQ-011 imem_data  in  32  instruction word, valid with imem_ack.
REQ-012 inst  out  32  instruction presented to decode.
REQ-013 inst_pc  out  32  PC of inst.
REQ-014 if_valid  out  1  inst/inst_pc valid.
REQ-015 perf_fetched, perf_stall  out  32 each  performance counters (see Configuration).

Function
REQ-016 At most one memory request outstanding; imem_req and imem_addr stay stable from assertion until the cycle imem_ack=1.
REQ-017 A 2-entry FIFO holds {pc, word}; an accepted ack pushes one entry and the fetch PC advances by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 FSM states: IDLE (no req), REQ (imem_req=1), DROP (imem_req=0, waiting to discard a stale response).
REQ-019 IDLE->REQ when FIFO occupancy after this cycle's push/pop is below 2; REQ->IDLE on ack if occupancy after push/pop equals 2; otherwise REQ stays REQ (back-to-back requests).
REQ-020 Pop occurs when if_valid=1 and if_en=1; push and pop in the same cycle are legal at any occupancy, including full.
REQ-021 if_valid = FIFO non-empty; when empty, inst=32'h0000_0000 (NOP) and inst_pc=fetch PC.
REQ-022 Latency: a word acked in cycle N appears on inst in cycle N+1; with same-cycle acks and if_en=1, throughput is one instruction per cycle.
REQ-023 redirect=1: FIFO cleared and fetch PC set to redirect_pc in the next cycle; if_valid=0 in that next cycle.
REQ-024 redirect while in REQ with no ack in that cycle -> DROP; the next ack is discarded, then -> REQ at the redirect PC.
REQ-025 redirect in the same cycle as ack: the acked word is discarded and the request is complete, so the FSM enters REQ at redirect_pc without passing through DROP.
REQ-026 if_rst takes priority over redirect and behaves as a redirect to RESET_PC, including DROP handling.
REQ-027 if_en=0 with the FIFO full: no request is issued; inst, inst_pc and if_valid are held unchanged.

Reset
REQ-028 rst=1 asynchronously: state=IDLE, fetch PC=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, if_valid=0, inst=0, inst_pc=RESET_PC, counters=0.
REQ-029 A response arriving for a request cut off by rst is ignored; after rst deasserts, the first request goes to RESET_PC.

Configuration
REQ-030 Macro FETCH_PERF_EN defined: perf_fetched increments on every pop, and perf_stall increments each cycle where if_en=1 and if_valid=0; both wrap at 2^32 and are cleared by rst and if_rst.
REQ-031 FETCH_PERF_EN undefined: perf_fetched and perf_stall are tied to 0 and no counter flops are synthesised.

Structure
REQ-032 The FSM state encoding (IDLE/DROP/REQ), the NOP word and the default RESET_PC belong in the shared package, alongside the existing pipeline defines.
REQ-033 One sub-module, fetch_queue: a parameterised-width 2-entry FIFO with push, pop, flush, full and empty.

Verification
REQ-034 Reset release, ack tied to req, if_en=1 -> imem_addr 0,4,8,...; inst_pc 0,4,8 one cycle after each ack; if_valid=1 continuously from cycle 2.
REQ-035 if_en=0 for 5 cycles after two words are fetched -> imem_req=0 once full; inst_pc holds 0; release -> 0,4,8 with no loss or duplication.
REQ-036 Ack delayed 3 cycles; redirect_pc=32'h40 asserted in the 2nd wait cycle -> stale word discarded; next imem_addr=32'h40; first valid inst_pc=32'h40.
REQ-037 redirect_pc=32'h100 in the same cycle as an ack for 32'h8 -> word 8 never appears on inst; next request addresses 32'h100.
REQ-038 if_rst and redirect_pc=32'h80 in the same cycle -> fetch resumes at RESET_PC.
REQ-039 FETCH_PERF_EN defined, 10 pops with 3 empty cycles -> perf_fetched=10, perf_stall=3; with the macro undefined, both read 0.
